// File: rtl/uart_fp_tx_pkg.sv
// uart_fp_tx_pkg: shared UART timing constants and Fp word geometry.
// Also holds the FSM state encodings used by the word and byte engines.
package uart_fp_tx_pkg;

  localparam int UART_CLK_FREQ  = 100_000_000;
  localparam int UART_BAUD_RATE = 460_800;

  function automatic int clks_per_bit(input int f, input int b);
    return f / b;
  endfunction

  localparam int UART_CLKS_PER_BIT =
    clks_per_bit(UART_CLK_FREQ, UART_BAUD_RATE);
  localparam int UART_FRAME_BITS = 10;

  localparam int K          = 17;
  localparam int N          = 17;
  localparam int FP_BITS    = K * N;
  localparam int N_FP_BYTES = (FP_BITS + 7) / 8;

  typedef logic [FP_BITS-1:0] uint_fp_t;

  typedef enum logic {
    W_IDLE,
    W_SEND
  } word_state_e;

  typedef enum logic [1:0] {
    B_IDLE,
    B_START,
    B_DATA,
    B_STOP
  } byte_state_e;

endpackage

// File: rtl/uart_fp_tx_if.sv
// uart_fp_tx_if: valid/ready word handshake into the Fp UART transmitter.
// The producer drives data and valid; the transmitter returns ready.
interface uart_fp_tx_if
  import uart_fp_tx_pkg::*;
#(
  parameter int DATA_BITS = FP_BITS
);

  logic [DATA_BITS-1:0] i_data;
  logic                 i_valid;
  logic                 o_ready;

  modport master (
    output i_data,
    output i_valid,
    input  o_ready
  );

  modport slave (
    input  i_data,
    input  i_valid,
    output o_ready
  );

endinterface

// File: rtl/uart_tx_byte.sv
// uart_tx_byte: one 8N1 frame, LSB first, registered line output.
// A start request during the final stop cycle chains frames with no idle gap.
module uart_tx_byte
  import uart_fp_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] i_byte,
  input  logic       i_start,
  output logic       o_txd,
  output logic       o_done
);

  localparam int CW =
    (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] BAUD_MAX = CW'(CLKS_PER_BIT - 1);

  byte_state_e   state_q, state_d;
  logic [CW-1:0] baud_cnt_q, baud_cnt_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    sh_q, sh_d;
  logic          txd_q, txd_d;
  logic          tick;

  assign tick   = (baud_cnt_q == BAUD_MAX);
  assign o_done = (state_q == B_STOP) && tick;
  assign o_txd  = txd_q;

  always_comb begin
    state_d    = state_q;
    baud_cnt_d = tick ? '0 : baud_cnt_q + 1'b1;
    bit_idx_d  = bit_idx_q;
    sh_d       = sh_q;
    txd_d      = txd_q;
    unique case (state_q)
      B_IDLE: begin
        baud_cnt_d = '0;
        txd_d      = 1'b1;
      end
      B_START: begin
        if (tick) begin
          state_d   = B_DATA;
          bit_idx_d = 3'd0;
          txd_d     = sh_q[0];
          sh_d      = sh_q >> 1;
        end
      end
      B_DATA: begin
        if (tick) begin
          if (bit_idx_q == 3'd7) begin
            state_d = B_STOP;
            txd_d   = 1'b1;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            txd_d     = sh_q[0];
            sh_d      = sh_q >> 1;
          end
        end
      end
      B_STOP: begin
        if (tick) begin
          state_d = B_IDLE;
        end
      end
    endcase
    // Next frame's start bit replaces the cycle after the stop bit.
    if (i_start && (state_q == B_IDLE || o_done)) begin
      state_d    = B_START;
      baud_cnt_d = '0;
      bit_idx_d  = 3'd0;
      sh_d       = i_byte;
      txd_d      = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= B_IDLE;
      baud_cnt_q <= '0;
      bit_idx_q  <= 3'd0;
      sh_q       <= 8'h00;
      txd_q      <= 1'b1;
    end else begin
      state_q    <= state_d;
      baud_cnt_q <= baud_cnt_d;
      bit_idx_q  <= bit_idx_d;
      sh_q       <= sh_d;
      txd_q      <= txd_d;
    end
  end

endmodule

// File: rtl/uart_fp_tx.sv
// uart_fp_tx: sends one Fp word as N_BYTES little-endian 8N1 frames.
// Owns the word shift register and byte index; bit timing is in uart_tx_byte.
module uart_fp_tx
  import uart_fp_tx_pkg::*;
#(
  parameter int CLK_FREQ  = UART_CLK_FREQ,
  parameter int BAUD_RATE = UART_BAUD_RATE,
  parameter int DATA_BITS = FP_BITS
) (
  input  logic        clk,
  input  logic        rst,
  uart_fp_tx_if.slave bus,
  output logic        o_txd,
  output logic        o_busy,
  output logic [5:0]  o_byte_idx
);

  localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD_RATE);
  localparam int N_BYTES      = (DATA_BITS + 7) / 8;
  localparam int PAD_BITS     = N_BYTES * 8;
  localparam logic [5:0] LAST_IDX = 6'(N_BYTES - 1);

  if (CLKS_PER_BIT < 2) begin : g_cpb_chk
    $error("uart_fp_tx: CLKS_PER_BIT must be at least 2");
  end

  word_state_e         state_q, state_d;
  logic [PAD_BITS-1:0] shift_q, shift_d;
  logic [5:0]          byte_idx_q, byte_idx_d;
  logic [PAD_BITS-1:0] data_pad;
  logic [7:0]          tx_byte;
  logic                tx_start;
  logic                byte_done;
  logic                ready;

  assign data_pad   = PAD_BITS'(bus.i_data);
  assign ready      = (state_q == W_IDLE);
  assign bus.o_ready = ready;
  assign o_busy     = ~ready;
  assign o_byte_idx = byte_idx_q;

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    byte_idx_d = byte_idx_q;
    tx_start   = 1'b0;
    tx_byte    = shift_q[7:0];
    unique case (state_q)
      W_IDLE: begin
        // Byte 0 goes straight from the input so the line drops at once.
        if (bus.i_valid) begin
          state_d    = W_SEND;
          tx_start   = 1'b1;
          tx_byte    = data_pad[7:0];
          shift_d    = data_pad >> 8;
          byte_idx_d = 6'd0;
        end
      end
      W_SEND: begin
        if (byte_done) begin
          if (byte_idx_q == LAST_IDX) begin
            state_d = W_IDLE;
          end else begin
            tx_start   = 1'b1;
            shift_d    = shift_q >> 8;
            byte_idx_d = byte_idx_q + 6'd1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= W_IDLE;
      shift_q    <= '0;
      byte_idx_q <= 6'd0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      byte_idx_q <= byte_idx_d;
    end
  end

  uart_tx_byte #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_byte (
    .clk     (clk),
    .rst     (rst),
    .i_byte  (tx_byte),
    .i_start (tx_start),
    .o_txd   (o_txd),
    .o_done  (byte_done)
  );

endmodule
